// File: rtl/vm_defs_pkg.sv
// Shared vending-machine definitions: default money width, controller FSM
// encoding and requester indices used by the money path blocks.
package vm_defs;

  localparam int VM_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } vm_state_e;

  localparam int REQ_DEP = 0;
  localparam int REQ_PAY = 1;
  localparam int REQ_OWN = 2;

  localparam logic [1:0] PTR_RST = 2'(REQ_OWN);

  // Requester index reached by stepping 'step' places after 'base', modulo 3.
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int unsigned step);
    int unsigned s;
    s = int'(base) + step;
    if (s >= 3) s = s - 3;
    if (s >= 3) s = s - 3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant, search begins just after
// the last granted index; the pointer moves only when a grant is issued.
module rr_arbiter3
  import vm_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  input  logic       en_i,
  output logic [2:0] gnt_o
);

  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (en_i) begin
      for (int unsigned k = 1; k <= 3; k++) begin
        if (req_i[rr_index(ptr_q, k)] && (gnt_o == '0)) begin
          gnt_o[rr_index(ptr_q, k)] = 1'b1;
          ptr_d                     = rr_index(ptr_q, k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PTR_RST;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/money_vault_ctrl.sv
// Sole writer of the machine balance: arbitrates deposit, change payout and
// owner withdrawal, range-checks each operation and answers with ack/nack.
module money_vault_ctrl
  import vm_defs::*;
#(
  parameter int WIDTH   = VM_WIDTH,
  parameter int RESERVE = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dep_req,
  input  logic [WIDTH-1:0] dep_amt,
  output logic             dep_ack,
  output logic             dep_nack,
  input  logic             pay_req,
  input  logic [WIDTH-1:0] pay_amt,
  output logic             pay_ack,
  output logic             pay_nack,
  input  logic             own_req,
  output logic             own_ack,
  output logic             own_nack,
  output logic [WIDTH-1:0] machine_money,
  output logic [WIDTH-1:0] owner_money,
  output logic             redlight,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RES     = WIDTH'(RESERVE);
  localparam logic             RED_RST = (RESERVE > 0);

  vm_state_e        state_q, state_d;
  logic [2:0]       req, gnt;
  logic             arb_en;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] amt_q, amt_d;
  logic [WIDTH-1:0] bal_q, bal_d;
  logic [WIDTH-1:0] own_q, own_d;
  logic             red_q, red_d;
  logic [2:0]       ack_q, ack_d, nack_q, nack_d;
  logic [WIDTH:0]   dep_sum;

  assign req    = {own_req, pay_req, dep_req};
  assign arb_en = (state_q == ST_IDLE);

  rr_arbiter3 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Carry bit of the widened sum is the overflow flag.
  assign dep_sum = {1'b0, bal_q} + {1'b0, amt_q};

  always_comb begin
    sel_d  = sel_q;
    amt_d  = amt_q;
    bal_d  = bal_q;
    own_d  = own_q;
    red_d  = red_q;
    ack_d  = '0;
    nack_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          sel_d = gnt;
          amt_d = gnt[REQ_PAY] ? pay_amt : (gnt[REQ_DEP] ? dep_amt : '0);
        end
      end
      ST_EXEC: begin
        if (sel_q[REQ_DEP]) begin
          if (dep_sum[WIDTH]) nack_d[REQ_DEP] = 1'b1;
          else begin
            bal_d           = dep_sum[WIDTH-1:0];
            ack_d[REQ_DEP]  = 1'b1;
          end
        end else if (sel_q[REQ_PAY]) begin
          if (amt_q > bal_q) nack_d[REQ_PAY] = 1'b1;
          else begin
            bal_d           = bal_q - amt_q;
            ack_d[REQ_PAY]  = 1'b1;
          end
        end else if (sel_q[REQ_OWN]) begin
          if (bal_q <= RES) nack_d[REQ_OWN] = 1'b1;
          else begin
            own_d           = bal_q - RES;
            bal_d           = RES;
            ack_d[REQ_OWN]  = 1'b1;
          end
        end
        red_d = (bal_d < RES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      amt_q  <= '0;
      bal_q  <= '0;
      own_q  <= '0;
      red_q  <= RED_RST;
      ack_q  <= '0;
      nack_q <= '0;
    end else begin
      sel_q  <= sel_d;
      amt_q  <= amt_d;
      bal_q  <= bal_d;
      own_q  <= own_d;
      red_q  <= red_d;
      ack_q  <= ack_d;
      nack_q <= nack_d;
    end
  end

  always_comb begin
    busy          = (state_q == ST_EXEC) || (state_q == ST_DONE);
    dep_ack       = ack_q[REQ_DEP];
    dep_nack      = nack_q[REQ_DEP];
    pay_ack       = ack_q[REQ_PAY];
    pay_nack      = nack_q[REQ_PAY];
    own_ack       = ack_q[REQ_OWN];
    own_nack      = nack_q[REQ_OWN];
    machine_money = bal_q;
    owner_money   = own_q;
    redlight      = red_q;
  end

endmodule

// File: tb/tb_money_vault_ctrl.sv
// Directed bench for money_vault_ctrl: stimulus pushes expected results into
// a queue, a negedge monitor pops and compares on every ack/nack pulse.
module tb_money_vault_ctrl;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         dep_req = 1'b0, pay_req = 1'b0, own_req = 1'b0;
  logic [W-1:0] dep_amt = '0, pay_amt = '0;
  logic         dep_ack, dep_nack, pay_ack, pay_nack, own_ack, own_nack;
  logic [W-1:0] machine_money, owner_money;
  logic         redlight, busy;

  typedef struct {
    logic [5:0]   pul;
    logic [W-1:0] mm;
    logic [W-1:0] om;
    logic         red;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   cyc_ack[3];
  logic [5:0] mon_pul;

  money_vault_ctrl #(.WIDTH(W), .RESERVE(100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dep_req       (dep_req),
    .dep_amt       (dep_amt),
    .dep_ack       (dep_ack),
    .dep_nack      (dep_nack),
    .pay_req       (pay_req),
    .pay_amt       (pay_amt),
    .pay_ack       (pay_ack),
    .pay_nack      (pay_nack),
    .own_req       (own_req),
    .own_ack       (own_ack),
    .own_nack      (own_nack),
    .machine_money (machine_money),
    .owner_money   (owner_money),
    .redlight      (redlight),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_pul = {own_nack, own_ack, pay_nack, pay_ack, dep_nack, dep_ack};
      if (mon_pul != 6'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse got %b required none", mon_pul);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulses", 32'(mon_pul), 32'(e.pul));
          chk("machine_money", 32'(machine_money), 32'(e.mm));
          chk("owner_money", 32'(owner_money), 32'(e.om));
          chk("redlight", 32'(redlight), 32'(e.red));
        end
      end
    end
  end

  task automatic push_exp(input int idx, input bit ack, input logic [W-1:0] mm,
                          input logic [W-1:0] om, input logic red);
    exp_t e;
    e.pul = 6'b1 << (2 * idx + (ack ? 0 : 1));
    e.mm  = mm;
    e.om  = om;
    e.red = red;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic v, input logic [W-1:0] amt);
    case (idx)
      0: begin dep_amt = amt; dep_req = v; end
      1: begin pay_amt = amt; pay_req = v; end
      default: own_req = v;
    endcase
  endtask

  function automatic logic pulse_of(input int idx);
    case (idx)
      0:       return dep_ack | dep_nack;
      1:       return pay_ack | pay_nack;
      default: return own_ack | own_nack;
    endcase
  endfunction

  task automatic wait_drop(input int idx);
    bit seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (pulse_of(idx)) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_req%0d got no response required ack_or_nack", idx);
    end
    cyc_ack[idx] = cyc;
    set_req(idx, 1'b0, '0);
  endtask

  task automatic txn(input int idx, input logic [W-1:0] amt, input bit ack,
                     input logic [W-1:0] mm, input logic [W-1:0] om, input logic red);
    push_exp(idx, ack, mm, om, red);
    @(negedge clk);
    set_req(idx, 1'b1, amt);
    wait_drop(idx);
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_machine_money", 32'(machine_money), 0);
    chk("rst_owner_money", 32'(owner_money), 0);
    chk("rst_redlight", 32'(redlight), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({own_nack, own_ack, pay_nack, pay_ack, dep_nack, dep_ack}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First deposit with busy-window check.
    push_exp(0, 1'b1, 11'd500, 11'd0, 1'b0);
    @(negedge clk);
    set_req(0, 1'b1, 11'd500);
    @(negedge clk);
    chk("busy_exec", 32'(busy), 1);
    chk("no_early_ack", 32'(dep_ack), 0);
    @(negedge clk);
    chk("busy_done", 32'(busy), 1);
    set_req(0, 1'b0, '0);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);

    txn(1, 11'd600,  1'b0, 11'd500,  11'd0, 1'b0);
    txn(1, 11'd120,  1'b1, 11'd380,  11'd0, 1'b0);
    txn(0, 11'd120,  1'b1, 11'd500,  11'd0, 1'b0);
    txn(0, 11'd1600, 1'b0, 11'd500,  11'd0, 1'b0);
    txn(0, 11'd1547, 1'b1, 11'd2047, 11'd0, 1'b0);
    txn(0, 11'd1,    1'b0, 11'd2047, 11'd0, 1'b0);
    txn(2, 11'd0,    1'b1, 11'd100,  11'd1947, 1'b0);
    txn(2, 11'd0,    1'b0, 11'd100,  11'd1947, 1'b0);

    // Last grant was owner, so simultaneous requests are served dep, pay, own.
    push_exp(0, 1'b1, 11'd300, 11'd1947, 1'b0);
    push_exp(1, 1'b1, 11'd270, 11'd1947, 1'b0);
    push_exp(2, 1'b1, 11'd100, 11'd170,  1'b0);
    @(negedge clk);
    set_req(0, 1'b1, 11'd200);
    set_req(1, 1'b1, 11'd30);
    set_req(2, 1'b1, '0);
    fork
      wait_drop(0);
      wait_drop(1);
      wait_drop(2);
    join
    @(negedge clk);
    chk("rr_spacing_dep_pay", 32'(cyc_ack[1] - cyc_ack[0]), 3);
    chk("rr_spacing_pay_own", 32'(cyc_ack[2] - cyc_ack[1]), 3);

    txn(0, 11'd0,   1'b1, 11'd100, 11'd170, 1'b0);
    txn(1, 11'd0,   1'b1, 11'd100, 11'd170, 1'b0);
    txn(1, 11'd100, 1'b1, 11'd0,   11'd170, 1'b1);
    txn(2, 11'd0,   1'b0, 11'd0,   11'd170, 1'b1);
    txn(0, 11'd250, 1'b1, 11'd250, 11'd170, 1'b0);

    // Asynchronous reset in the middle of a deposit's EXEC cycle.
    @(negedge clk);
    set_req(0, 1'b1, 11'd10);
    @(posedge clk);
    #2;
    chk("abort_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_machine_money", 32'(machine_money), 0);
    chk("abort_owner_money", 32'(owner_money), 0);
    chk("abort_redlight", 32'(redlight), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_dep_ack", 32'(dep_ack), 0);
    set_req(0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_abort_balance", 32'(machine_money), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
